// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues instruction requests on the SRAM-like bus
// and forwards accepted PCs to if_stage, tracking in-flight requests cancelled by flushes.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic [32:0] br_bus,
    input  logic [32:0] exception_bus,
    output logic        pfs_to_fs_valid,
    output logic [31:0] pfs_to_fs_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    output logic        resp_discard
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [31:0]        pc, pc_next;
    logic [CNT_W-1:0]   outstanding, outstanding_next;
    logic [CNT_W-1:0]   cancel_cnt, cancel_next;
    logic               br_buf_valid, br_buf_valid_next;
    logic [31:0]        br_buf_target, br_buf_target_next;
    logic               flush_buf_valid, flush_buf_valid_next;
    logic [31:0]        flush_buf_pc, flush_buf_pc_next;

    logic               br_taken, flush;
    logic [31:0]        br_target, ex_pc, seq_pc;
    logic               req_int, handshake, data_ok_eff, discard, fs_valid;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];
    assign flush     = exception_bus[32];
    assign ex_pc     = exception_bus[31:0];

    assign req_int     = (state == S_REQ) && (32'(outstanding) < MAX_OUTSTANDING);
    assign handshake   = req_int && inst_sram_addr_ok;
    // A stray data_ok with nothing in flight is ignored so the counter saturates at zero
    assign data_ok_eff = inst_sram_data_ok && (outstanding != '0);
    assign discard     = data_ok_eff && (cancel_cnt != '0);

    assign seq_pc = br_taken     ? br_target :
                    br_buf_valid ? br_buf_target :
                                   pc + 32'd4;

    // Next-state, PC, buffer and counter logic
    always_comb begin
        state_next           = state;
        pc_next              = pc;
        br_buf_valid_next    = br_buf_valid;
        br_buf_target_next   = br_buf_target;
        flush_buf_valid_next = flush_buf_valid;
        flush_buf_pc_next    = flush_buf_pc;
        fs_valid             = 1'b0;
        outstanding_next     = CNT_W'(outstanding + CNT_W'(handshake) - CNT_W'(data_ok_eff));
        cancel_next          = CNT_W'(cancel_cnt - CNT_W'(discard));

        case (state)
            S_REQ: begin
                if (handshake) begin
                    if (flush || flush_buf_valid) begin
                        pc_next              = flush ? ex_pc : flush_buf_pc;
                        flush_buf_valid_next = 1'b0;
                        br_buf_valid_next    = 1'b0;
                        cancel_next          = CNT_W'(cancel_next + CNT_W'(1));
                    end else if (fs_allowin) begin
                        fs_valid          = 1'b1;
                        pc_next           = seq_pc;
                        br_buf_valid_next = 1'b0;
                    end else begin
                        state_next = S_HOLD;
                        if (br_taken) begin
                            br_buf_valid_next  = 1'b1;
                            br_buf_target_next = br_target;
                        end
                    end
                end else if (flush) begin
                    // The address on the bus must stay put until accepted
                    if (req_int) begin
                        flush_buf_valid_next = 1'b1;
                        flush_buf_pc_next    = ex_pc;
                    end else begin
                        pc_next              = ex_pc;
                        flush_buf_valid_next = 1'b0;
                    end
                    br_buf_valid_next = 1'b0;
                end else if (br_taken && !flush_buf_valid) begin
                    br_buf_valid_next  = 1'b1;
                    br_buf_target_next = br_target;
                end
            end
            S_HOLD: begin
                fs_valid = !flush;
                if (flush) begin
                    pc_next           = ex_pc;
                    state_next        = S_REQ;
                    br_buf_valid_next = 1'b0;
                end else if (fs_allowin) begin
                    pc_next           = seq_pc;
                    state_next        = S_REQ;
                    br_buf_valid_next = 1'b0;
                end else if (br_taken) begin
                    br_buf_valid_next  = 1'b1;
                    br_buf_target_next = br_target;
                end
            end
            default: state_next = S_REQ;
        endcase

        // Every request still in flight after a flush, held one included, is stale
        if (flush) begin
            cancel_next = outstanding_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_REQ;
            pc              <= RESET_PC;
            outstanding     <= '0;
            cancel_cnt      <= '0;
            br_buf_valid    <= 1'b0;
            br_buf_target   <= '0;
            flush_buf_valid <= 1'b0;
            flush_buf_pc    <= '0;
        end else begin
            assert (!(inst_sram_data_ok && (outstanding == '0)));
            state           <= state_next;
            pc              <= pc_next;
            outstanding     <= outstanding_next;
            cancel_cnt      <= cancel_next;
            br_buf_valid    <= br_buf_valid_next;
            br_buf_target   <= br_buf_target_next;
            flush_buf_valid <= flush_buf_valid_next;
            flush_buf_pc    <= flush_buf_pc_next;
        end
    end

    assign inst_sram_req   = !reset && req_int;
    assign inst_sram_addr  = reset ? 32'd0 : pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wdata = 32'd0;
    assign pfs_to_fs_valid = !reset && fs_valid;
    assign pfs_to_fs_bus   = reset ? 32'd0 : pc;
    assign resp_discard    = !reset && discard;

endmodule
